// File: rtl/mem_pkg.sv
// mem_pkg: store size encodings, store FSM states and the size-to-byte-count helper.
package mem_pkg;
   typedef enum logic [1:0] {SIZE_BYTE, SIZE_HALF, SIZE_WORD, SIZE_RSVD} size_e;
   typedef enum logic [1:0] {IDLE, WRITE, REJECT} state_e;
   function automatic logic [2:0] byte_count(input logic [1:0] size);
      return size == SIZE_BYTE ? 3'd1 : size == SIZE_HALF ? 3'd2 : size == SIZE_WORD ? 3'd4 : 3'd0;
   endfunction
endpackage

// File: rtl/byte_store_memory_if.sv
// byte_store_memory_if: store request handshake and completion status.
interface byte_store_memory_if;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_address;
   logic [31:0] req_data;
   logic [1:0]  req_size;
   logic        busy;
   logic        done;
   logic        illegal_address;
   modport master (output req_valid, req_address, req_data, req_size,
                   input req_ready, busy, done, illegal_address);
   modport slave (input req_valid, req_address, req_data, req_size,
                  output req_ready, busy, done, illegal_address);
endinterface

// File: rtl/byte_ram.sv
// byte_ram: 4*depth x 8 array, one synchronous write port and one combinational read port.
module byte_ram #(
   parameter int depth = 512
) (
   input  logic                         clk,
   input  logic                         we,
   input  logic [$clog2(4*depth)-1:0]   waddr,
   input  logic [7:0]                   wdata,
   input  logic [$clog2(4*depth)-1:0]   raddr,
   output logic [7:0]                   rdata
);
   (* ram_init_file = "byte_ram.mif" *) logic [7:0] mem [4*depth];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end
   assign rdata = mem[raddr];
endmodule

// File: rtl/byte_store_memory.sv
// byte_store_memory: byte-sequential store FSM over byte_ram with a combinational byte read port.
// Optional STORE_ALIGN_CHECK_EN rejects misaligned half/word stores.
module byte_store_memory
   import mem_pkg::*;
#(
   parameter int depth = 512
) (
   input  logic                clk,
   input  logic                reset,
   byte_store_memory_if.slave  bus,
   input  logic [31:0]         read_address,
   output logic [7:0]          read_data,
   output logic                read_illegal
);
   localparam int bytes = 4 * depth;
   localparam int aw = $clog2(bytes);
   state_e state, next;
   logic [aw-1:0] addr_q;
   logic [31:0] data_q;
   logic [1:0] size_q, k;
   logic done_d, ill_d, misalign, bad, we;
   logic [7:0] rdata;
`ifdef STORE_ALIGN_CHECK_EN
   assign misalign = (bus.req_size == SIZE_HALF && bus.req_address[0]) ||
                     (bus.req_size == SIZE_WORD && bus.req_address[1:0] != 2'b00);
`else
   assign misalign = 1'b0;
`endif
   // 33-bit sum so addresses near 2^32 cannot wrap into range
   assign bad = bus.req_size == SIZE_RSVD || misalign ||
                {1'b0, bus.req_address} + 33'(byte_count(bus.req_size)) - 33'd1 >= 33'(bytes);
   assign bus.req_ready = state == IDLE;
   assign bus.busy = state != IDLE;
   always_comb begin
      next = state;
      done_d = 1'b0;
      ill_d = 1'b0;
      unique case (state)
         IDLE: next = bus.req_valid ? (bad ? REJECT : WRITE) : IDLE;
         WRITE: begin
            next = k == 2'(byte_count(size_q) - 3'd1) ? IDLE : WRITE;
            done_d = next == IDLE;
         end
         REJECT: begin
            next = IDLE;
            done_d = 1'b1;
            ill_d = 1'b1;
         end
         default: next = IDLE;
      endcase
   end
   // a reset edge must not commit the byte that was pending
   assign we = state == WRITE && !reset;
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         k <= 2'd0;
         bus.done <= 1'b0;
         bus.illegal_address <= 1'b0;
      end else begin
         state <= next;
         k <= state == WRITE ? k + 2'd1 : 2'd0;
         bus.done <= done_d;
         bus.illegal_address <= ill_d;
         if (bus.req_valid && bus.req_ready) begin
            addr_q <= bus.req_address[aw-1:0];
            data_q <= bus.req_data;
            size_q <= bus.req_size;
         end
      end
   end
   assign read_illegal = read_address >= 32'(bytes);
   assign read_data = read_illegal ? 8'h00 : rdata;
   byte_ram #(.depth(depth)) u_ram (
      .clk(clk),
      .we(we),
      .waddr(addr_q + aw'(k)),
      .wdata(8'(data_q >> {k, 3'b000})),
      .raddr(read_address[aw-1:0]),
      .rdata(rdata)
   );
endmodule

// File: tb/tb_byte_store_memory.sv
// tb_byte_store_memory: randomized store/read checks against a byte-array reference model.
module tb_byte_store_memory;
   localparam int nbytes = 2048;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic [31:0] read_address = 32'd0;
   logic [7:0] read_data;
   logic read_illegal;
   int tests = 0, failed = 0;
   logic [7:0] ref_mem [nbytes];
   byte_store_memory_if bus();
   byte_store_memory #(.depth(512)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus),
      .read_address(read_address),
      .read_data(read_data),
      .read_illegal(read_illegal)
   );
   always #5 clk = ~clk;
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
   function automatic logic [7:0] exp_rd(input logic [31:0] a);
      return a < nbytes ? ref_mem[a[10:0]] : 8'h00;
   endfunction
   // store semantics straight from the rules: N bytes little-endian, reject on size/range/alignment
   task automatic model_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                              output int lat, output logic ill);
      int n;
      longint last;
      n = s == 2'd0 ? 1 : s == 2'd1 ? 2 : s == 2'd2 ? 4 : 0;
      last = longint'({32'd0, a}) + n - 1;
      ill = s == 2'd3 || last >= nbytes;
`ifdef STORE_ALIGN_CHECK_EN
      if ((s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00)) ill = 1'b1;
`endif
      if (!ill) for (int j = 0; j < n; j++) ref_mem[int'(a) + j] = d[8*j +: 8];
      lat = ill ? 2 : n + 1;
   endtask
   // called at a negedge while idle; returns at the negedge of the done cycle
   task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                            output int lat, output logic ill, output int ready_low);
      bus.req_valid = 1'b1;
      bus.req_address = a;
      bus.req_data = d;
      bus.req_size = s;
      @(negedge clk);
      bus.req_valid = 1'b0;
      bus.req_address = $urandom;
      bus.req_data = $urandom;
      bus.req_size = 2'($urandom);
      lat = 0;
      ill = 1'b0;
      ready_low = 0;
      for (int i = 1; i <= 8; i++) begin
         if (bus.done) begin
            lat = i;
            ill = bus.illegal_address;
            break;
         end
         if (!bus.req_ready) ready_low++;
         if (i < 8) @(negedge clk);
      end
   endtask
   task automatic test_reset();
      bus.req_valid = 1'b0;
      bus.req_address = 32'd0;
      bus.req_data = 32'd0;
      bus.req_size = 2'd0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      tests++; if (bus.req_ready !== 1'b1) begin failed++; $display("FAIL reset_ready: got %b want 1", bus.req_ready); end
      tests++; if (bus.busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      tests++; if (bus.done !== 1'b0) begin failed++; $display("FAIL reset_done: got %b want 0", bus.done); end
      tests++; if (bus.illegal_address !== 1'b0) begin failed++; $display("FAIL reset_illegal: got %b want 0", bus.illegal_address); end
   endtask
   task automatic test_fill();
      int lat, elat, rl;
      logic ill, eill;
      logic [31:0] d;
      for (int w = 0; w < nbytes / 4; w++) begin
         d = $urandom;
         model_store(32'(4 * w), d, 2'd2, elat, eill);
         run_store(32'(4 * w), d, 2'd2, lat, ill, rl);
         tests++;
         if (lat !== elat || ill !== eill) begin
            failed++;
            $display("FAIL fill_store @%0h: lat=%0d ill=%b want lat=%0d ill=%b", 4 * w, lat, ill, elat, eill);
         end
      end
   endtask
   task automatic test_scan(input string tag);
      int bad = 0;
      for (int i = 0; i < nbytes + 4; i++) begin
         read_address = 32'(i);
         #1;
         if (read_data !== exp_rd(32'(i)) || read_illegal !== (i >= nbytes)) bad++;
      end
      tests++;
      if (bad != 0) begin failed++; $display("FAIL scan_%s: %0d bytes differ, want 0", tag, bad); end
   endtask
   task automatic test_word();
      int lat, elat, rl;
      logic ill, eill;
      model_store(32'h10, 32'hDEADBEEF, 2'd2, elat, eill);
      run_store(32'h10, 32'hDEADBEEF, 2'd2, lat, ill, rl);
      tests++; if (lat !== 5 || ill !== 1'b0) begin failed++; $display("FAIL word_done: lat=%0d ill=%b want lat=5 ill=0", lat, ill); end
      tests++; if (rl !== 4) begin failed++; $display("FAIL word_ready_low: got %0d cycles want 4", rl); end
      tests++; if (bus.req_ready !== 1'b1) begin failed++; $display("FAIL word_ready_in_done: got %b want 1", bus.req_ready); end
      @(negedge clk);
      tests++; if (bus.done !== 1'b0) begin failed++; $display("FAIL word_done_width: done still %b want 0", bus.done); end
      for (int i = 0; i < 4; i++) begin
         logic [31:0] c;
         c = 32'hDEADBEEF;
         read_address = 32'h10 + 32'(i);
         #1;
         tests++;
         if (read_data !== c[8*i +: 8]) begin failed++; $display("FAIL word_read @%0h: got %h want %h", read_address, read_data, c[8*i +: 8]); end
      end
   endtask
   task automatic test_boundary();
      int lat, elat, rl;
      logic ill, eill;
      model_store(32'h7FF, 32'h0000005A, 2'd0, elat, eill);
      run_store(32'h7FF, 32'h0000005A, 2'd0, lat, ill, rl);
      tests++; if (lat !== 2 || ill !== 1'b0) begin failed++; $display("FAIL byte_7ff: lat=%0d ill=%b want lat=2 ill=0", lat, ill); end
      model_store(32'h7FF, 32'h0000A5C3, 2'd1, elat, eill);
      run_store(32'h7FF, 32'h0000A5C3, 2'd1, lat, ill, rl);
      tests++; if (lat !== 2 || ill !== 1'b1) begin failed++; $display("FAIL half_7ff: lat=%0d ill=%b want lat=2 ill=1", lat, ill); end
      read_address = 32'h7FF;
      #1;
      tests++; if (read_data !== 8'h5A || read_illegal !== 1'b0) begin failed++; $display("FAIL read_7ff: got %h/%b want 5a/0", read_data, read_illegal); end
      read_address = 32'h800;
      #1;
      tests++; if (read_data !== 8'h00 || read_illegal !== 1'b1) begin failed++; $display("FAIL read_800: got %h/%b want 00/1", read_data, read_illegal); end
      read_address = 32'hFFFFFFFF;
      #1;
      tests++; if (read_data !== 8'h00 || read_illegal !== 1'b1) begin failed++; $display("FAIL read_ffffffff: got %h/%b want 00/1", read_data, read_illegal); end
   endtask
   task automatic test_reject();
      int lat, elat, rl;
      logic ill, eill;
      model_store(32'h0, 32'h12345678, 2'd3, elat, eill);
      run_store(32'h0, 32'h12345678, 2'd3, lat, ill, rl);
      tests++; if (lat !== 2 || ill !== 1'b1) begin failed++; $display("FAIL size3: lat=%0d ill=%b want lat=2 ill=1", lat, ill); end
      model_store(32'hFFFFFFFE, 32'hCAFEF00D, 2'd2, elat, eill);
      run_store(32'hFFFFFFFE, 32'hCAFEF00D, 2'd2, lat, ill, rl);
      tests++; if (lat !== 2 || ill !== 1'b1) begin failed++; $display("FAIL wrap_word: lat=%0d ill=%b want lat=2 ill=1", lat, ill); end
      test_scan("after_reject");
   endtask
   task automatic test_back_to_back();
      int elat, lat;
      logic eill;
      model_store(32'h20, 32'h00001234, 2'd1, elat, eill);
      model_store(32'h22, 32'h00000099, 2'd0, elat, eill);
      bus.req_valid = 1'b1;
      bus.req_address = 32'h20;
      bus.req_data = 32'h00001234;
      bus.req_size = 2'd1;
      @(negedge clk);
      bus.req_address = 32'h22;
      bus.req_data = 32'h00000099;
      bus.req_size = 2'd0;
      lat = 0;
      for (int i = 1; i <= 8; i++) begin
         if (bus.done) begin lat = i; break; end
         if (i < 8) @(negedge clk);
      end
      tests++; if (lat !== 3 || bus.req_ready !== 1'b1) begin failed++; $display("FAIL b2b_first: lat=%0d ready=%b want lat=3 ready=1", lat, bus.req_ready); end
      @(negedge clk);
      bus.req_valid = 1'b0;
      tests++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin failed++; $display("FAIL b2b_accept: busy=%b done=%b want 1/0", bus.busy, bus.done); end
      @(negedge clk);
      tests++; if (bus.done !== 1'b1 || bus.illegal_address !== 1'b0) begin failed++; $display("FAIL b2b_second_done: done=%b ill=%b want 1/0", bus.done, bus.illegal_address); end
      for (int i = 0; i < 3; i++) begin
         read_address = 32'h20 + 32'(i);
         #1;
         tests++;
         if (read_data !== exp_rd(read_address)) begin failed++; $display("FAIL b2b_read @%0h: got %h want %h", read_address, read_data, exp_rd(read_address)); end
      end
   endtask
   task automatic test_reset_mid();
      int seen = 0;
      ref_mem[32'h40] = 8'h44;
      ref_mem[32'h41] = 8'h33;
      bus.req_valid = 1'b1;
      bus.req_address = 32'h40;
      bus.req_data = 32'h11223344;
      bus.req_size = 2'd2;
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      tests++; if (bus.req_ready !== 1'b1 || bus.busy !== 1'b0) begin failed++; $display("FAIL midreset_state: ready=%b busy=%b want 1/0", bus.req_ready, bus.busy); end
      for (int i = 0; i < 5; i++) begin
         if (bus.done) seen++;
         @(negedge clk);
      end
      tests++; if (seen != 0) begin failed++; $display("FAIL midreset_done: %0d done cycles want 0", seen); end
      for (int i = 0; i < 4; i++) begin
         read_address = 32'h40 + 32'(i);
         #1;
         tests++;
         if (read_data !== exp_rd(read_address)) begin failed++; $display("FAIL midreset_read @%0h: got %h want %h", read_address, read_data, exp_rd(read_address)); end
      end
   endtask
   task automatic test_align();
      int lat, elat, rl;
      logic ill, eill;
      model_store(32'h42, 32'h89ABCDEF, 2'd2, elat, eill);
      run_store(32'h42, 32'h89ABCDEF, 2'd2, lat, ill, rl);
      tests++; if (lat !== elat || ill !== eill) begin failed++; $display("FAIL align_word42: lat=%0d ill=%b want lat=%0d ill=%b", lat, ill, elat, eill); end
      for (int i = 0; i < 4; i++) begin
         read_address = 32'h42 + 32'(i);
         #1;
         tests++;
         if (read_data !== exp_rd(read_address)) begin failed++; $display("FAIL align_read @%0h: got %h want %h", read_address, read_data, exp_rd(read_address)); end
      end
   endtask
   task automatic test_random();
      int lat, elat, rl;
      logic ill, eill;
      logic [31:0] a, d, ra;
      logic [1:0] s;
      for (int t = 0; t < 300; t++) begin
         a = $urandom_range(0, 3) == 0 ? $urandom : 32'($urandom_range(0, nbytes + 7));
         d = $urandom;
         s = 2'($urandom_range(0, 3));
         model_store(a, d, s, elat, eill);
         run_store(a, d, s, lat, ill, rl);
         tests++;
         if (lat !== elat || ill !== eill) begin
            failed++;
            $display("FAIL random_store a=%h s=%0d: lat=%0d ill=%b want lat=%0d ill=%b", a, s, lat, ill, elat, eill);
         end
         ra = 32'($urandom_range(0, nbytes + 3));
         read_address = ra;
         #1;
         tests++;
         if (read_data !== exp_rd(ra)) begin failed++; $display("FAIL random_read @%h: got %h want %h", ra, read_data, exp_rd(ra)); end
      end
      test_scan("after_random");
   endtask
   initial begin
      test_reset();
      test_fill();
      test_scan("after_fill");
      test_word();
      test_boundary();
      test_reject();
      test_back_to_back();
      test_reset_mid();
      test_align();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end
endmodule
